// File: rtl/hall_quadrature_encoder.sv
// Hall quadrature transmitter: turns move commands (steps, direction, period)
// into Hall_A/Hall_B edges while tracking position and revolution count.
module hall_quadrature_encoder #(
    parameter int COUNTS_PER_REV = 348,
    parameter int PERIOD_W       = 20,
    parameter int STEPS_W        = 16
) (
    input  logic                clk_48,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_dir,
    input  logic [STEPS_W-1:0]  cmd_steps,
    input  logic [PERIOD_W-1:0] cmd_period,
    input  logic                abort,
    output logic                Hall_A,
    output logic                Hall_B,
    output logic                dir,
    output logic [11:0]         pos,
    output logic [3:0]          cyc,
    output logic                busy,
    output logic                done
);

    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_RUN   = 2'd1;
    localparam logic [1:0]  S_DONE  = 2'd2;
    localparam logic [11:0] POS_MAX = 12'(COUNTS_PER_REV - 1);

    logic [1:0]          state;
    logic [PERIOD_W-1:0] timer;
    logic [PERIOD_W-1:0] period;
    logic [STEPS_W-1:0]  steps_left;
    logic [PERIOD_W-1:0] period_clamped;
    logic                step_due;

    // Periods below 2 would put Hall edges closer than the decoder can resolve.
    assign period_clamped = (cmd_period < PERIOD_W'(2)) ? PERIOD_W'(2) : cmd_period;
    assign step_due       = (timer == period - PERIOD_W'(1));

    assign cmd_ready = (state == S_IDLE) && reset_n;
    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk_48) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            timer      <= '0;
            period     <= '0;
            steps_left <= '0;
            Hall_A     <= 1'b0;
            Hall_B     <= 1'b0;
            dir        <= 1'b0;
            pos        <= '0;
            cyc        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        dir        <= cmd_dir;
                        steps_left <= cmd_steps;
                        period     <= period_clamped;
                        timer      <= '0;
                        state      <= (cmd_steps == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state <= S_DONE;
                    end else if (step_due) begin
                        timer      <= '0;
                        steps_left <= steps_left - STEPS_W'(1);
                        if (steps_left == STEPS_W'(1))
                            state <= S_DONE;
                        // Gray step: the channel to toggle depends on whether A==B.
                        if (dir ^ (Hall_A == Hall_B))
                            Hall_A <= ~Hall_A;
                        else
                            Hall_B <= ~Hall_B;
                        if (dir) begin
                            if (pos == POS_MAX) begin
                                pos <= '0;
                                cyc <= cyc + 4'd1;
                            end else begin
                                pos <= pos + 12'd1;
                            end
                        end else begin
                            if (pos == '0) begin
                                pos <= POS_MAX;
                                cyc <= cyc - 4'd1;
                            end else begin
                                pos <= pos - 12'd1;
                            end
                        end
                    end else begin
                        timer <= timer + PERIOD_W'(1);
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hall_quadrature_encoder.sv
// Scoreboard bench for hall_quadrature_encoder: stimulus queues expected Hall
// edges and done pulses; a negedge monitor pops and compares them.
module tb_hall_quadrature_encoder;

    logic        clk_48 = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_dir = 1'b0;
    logic [15:0] cmd_steps = '0;
    logic [19:0] cmd_period = '0;
    logic        abort = 1'b0;
    logic        cmd_ready, Hall_A, Hall_B, dir, busy, done;
    logic [11:0] pos;
    logic [3:0]  cyc;

    hall_quadrature_encoder #(.COUNTS_PER_REV(348), .PERIOD_W(20), .STEPS_W(16)) dut (
        .clk_48(clk_48), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort),
        .Hall_A(Hall_A), .Hall_B(Hall_B), .dir(dir), .pos(pos), .cyc(cyc),
        .busy(busy), .done(done)
    );

    always #5 clk_48 = ~clk_48;

    int edge_cnt = 0;
    always @(posedge clk_48) edge_cnt <= edge_cnt + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic logic [1:0] fwd(input logic [1:0] h);
        case (h)
            2'b00: return 2'b01;
            2'b01: return 2'b11;
            2'b11: return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] rev(input logic [1:0] h);
        case (h)
            2'b00: return 2'b10;
            2'b10: return 2'b11;
            2'b11: return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    typedef struct { int t; logic [1:0] h; } edge_t;
    typedef struct { int t; int p; int c; logic d; logic [1:0] h; } done_t;
    edge_t eq[$];
    done_t dq[$];

    // Reference position model
    logic [1:0] m_hall = 2'b00;
    int         m_pos = 0;
    int         m_cyc = 0;

    task automatic m_step(input logic d);
        if (d) begin
            m_hall = fwd(m_hall);
            if (m_pos == 347) begin m_pos = 0; m_cyc = (m_cyc + 1) % 16; end
            else m_pos++;
        end else begin
            m_hall = rev(m_hall);
            if (m_pos == 0) begin m_pos = 347; m_cyc = (m_cyc + 15) % 16; end
            else m_pos--;
        end
    endtask

    task automatic m_reset();
        m_hall = 2'b00; m_pos = 0; m_cyc = 0;
    endtask

    // Monitor: also acts as a minimal quadrature decoder for the loopback test.
    logic [1:0] prev_h;
    logic [1:0] cur_h;
    int dec_up = 0;
    int dec_dn = 0;
    always @(negedge clk_48) begin
        cur_h = {Hall_A, Hall_B};
        if (!reset_n) begin
            prev_h = cur_h;
        end else begin
            if (cur_h !== prev_h) begin
                chk("one_channel", $countones(cur_h ^ prev_h), 1);
                if (cur_h == fwd(prev_h)) dec_up++;
                else if (cur_h == rev(prev_h)) dec_dn++;
                if (eq.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_edge: got hall %b expected none (edge %0d)", cur_h, edge_cnt);
                end else begin
                    edge_t e;
                    e = eq.pop_front();
                    chk("edge_time", edge_cnt, e.t);
                    chk("edge_hall", int'(cur_h), int'(e.h));
                end
                prev_h = cur_h;
            end
            if (done) begin
                if (dq.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_done: got done=1 expected 0 (edge %0d)", edge_cnt);
                end else begin
                    done_t r;
                    r = dq.pop_front();
                    chk("done_time", edge_cnt, r.t);
                    chk("done_pos", int'(pos), r.p);
                    chk("done_cyc", int'(cyc), r.c);
                    chk("done_dir", int'(dir), int'(r.d));
                    chk("done_hall", int'({Hall_A, Hall_B}), int'(r.h));
                end
            end
        end
    end

    task automatic wait_edge(input int e);
        while (edge_cnt < e) begin
            @(posedge clk_48); #1;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_hall"}, int'({Hall_A, Hall_B}), 0);
        chk({tag, "_pos"}, int'(pos), 0);
        chk({tag, "_cyc"}, int'(cyc), 0);
        chk({tag, "_dir"}, int'(dir), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_ready"}, int'(cmd_ready), 0);
    endtask

    // Drive one command; queue its edges and (optionally) its done pulse.
    task automatic issue(input logic d, input int steps, input int per, input int n_edges,
                         input int abort_at, input bit push_done, output int k, output int de);
        int p;
        p = (per < 2) ? 2 : per;
        @(posedge clk_48); #1;
        chk("ready_before_cmd", int'(cmd_ready), 1);
        k  = edge_cnt + 1;
        de = (abort_at > 0) ? k + abort_at : k + steps * p;
        for (int i = 1; i <= n_edges; i++) begin
            m_step(d);
            eq.push_back('{k + i * p, m_hall});
        end
        if (push_done) dq.push_back('{de, m_pos, m_cyc, d, m_hall});
        cmd_valid = 1'b1; cmd_dir = d; cmd_steps = 16'(steps); cmd_period = 20'(per);
        @(posedge clk_48); #1;
        cmd_valid = 1'b0;
        @(negedge clk_48);
        chk("busy_after_accept", int'(busy), int'(steps != 0));
    endtask

    task automatic run_move(input logic d, input int steps, input int per,
                            input int n_edges, input int abort_at);
        int k, de;
        issue(d, steps, per, n_edges, abort_at, 1'b1, k, de);
        if (abort_at > 0) begin
            wait_edge(k + abort_at - 1);
            abort = 1'b1;
            @(posedge clk_48); #1;
            abort = 1'b0;
        end
        wait_edge(de + 1);
        @(negedge clk_48);
        chk("ready_after_done", int'(cmd_ready), 1);
        chk("busy_after_done", int'(busy), 0);
    endtask

    task automatic reset_pulse();
        @(posedge clk_48); #1;
        reset_n = 1'b0;
        @(posedge clk_48); #1;
        @(negedge clk_48);
        chk_reset_outputs("rst");
        @(posedge clk_48); #1;
        reset_n = 1'b1;
        m_reset();
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: got no finish expected finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int k, de, up0, dn0;

        // Reset held 3 cycles with cmd_valid asserted
        reset_n = 1'b0; cmd_valid = 1'b1; cmd_steps = 16'd5; cmd_period = 20'd3;
        repeat (3) @(posedge clk_48);
        @(negedge clk_48);
        chk_reset_outputs("por");
        @(posedge clk_48); #1;
        reset_n = 1'b1; cmd_valid = 1'b0;
        @(negedge clk_48);
        chk("ready_after_release", int'(cmd_ready), 1);
        chk("hall_after_release", int'({Hall_A, Hall_B}), 0);

        // Forward 4 steps, period 10
        run_move(1'b1, 4, 10, 4, 0);
        chk("fwd_pos", int'(pos), 4);
        chk("fwd_dir", int'(dir), 1);
        chk("fwd_hall", int'({Hall_A, Hall_B}), 0);

        // Reverse wrap from 0
        reset_pulse();
        run_move(1'b0, 1, 5, 1, 0);
        chk("rev_hall", int'({Hall_A, Hall_B}), 2);
        chk("rev_pos", int'(pos), 347);
        chk("rev_cyc", int'(cyc), 15);
        chk("rev_dir", int'(dir), 0);

        // Full revolution at minimum period, decoded by the monitor
        reset_pulse();
        up0 = dec_up; dn0 = dec_dn;
        run_move(1'b1, 348, 2, 348, 0);
        chk("rev_full_pos", int'(pos), 0);
        chk("rev_full_cyc", int'(cyc), 1);
        chk("loop_up_count", dec_up - up0, 348);
        chk("loop_dn_count", dec_dn - dn0, 0);

        // Abort between steps, then abort on a step edge
        run_move(1'b1, 10, 10, 2, 25);
        chk("abort25_pos", int'(pos), 2);
        run_move(1'b1, 10, 10, 2, 30);
        chk("abort30_pos", int'(pos), 4);

        // Zero-step command: done only, Hall unchanged
        run_move(1'b0, 0, 7, 0, 0);
        chk("zero_pos", int'(pos), 4);
        chk("zero_hall", int'({Hall_A, Hall_B}), 0);
        chk("zero_dir", int'(dir), 0);

        // Period 0 clamps to 2
        run_move(1'b1, 2, 0, 2, 0);
        chk("p0_pos", int'(pos), 6);
        chk("p0_hall", int'({Hall_A, Hall_B}), 3);

        // Reset in the middle of a move: no done pulse
        issue(1'b1, 10, 4, 2, 0, 1'b0, k, de);
        wait_edge(k + 9);
        reset_n = 1'b0;
        @(posedge clk_48); #1;
        @(negedge clk_48);
        chk_reset_outputs("midrst");
        @(posedge clk_48); #1;
        reset_n = 1'b1;
        m_reset();
        repeat (10) @(posedge clk_48);
        @(negedge clk_48);
        chk("midrst_ready", int'(cmd_ready), 1);
        chk("midrst_busy", int'(busy), 0);

        chk("edge_queue_empty", eq.size(), 0);
        chk("done_queue_empty", dq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
